// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_fetch_queue : in-order fetch buffer between the PC stage and an       |
// |                   AXI-lite read port, with flush-aware response dropping. |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module ifu_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_pc_valid,
  output logic              fetch_pc_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] ar_addr,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_valid,
  output logic              r_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  output logic              inst_valid,
  input  logic              inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("ifu_fetch_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  fill_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  pend_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_flush;
  logic [CNT_W:0]    in_flight;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  err_mem;
  logic [DEPTH-1:0]  filled;

  logic              credit_ok;
  logic              ar_fire;
  logic              r_fire;
  logic              fill;
  logic              rel;

  // Dropped-but-outstanding reads still occupy bus credit until they return.
  assign in_flight = {1'b0, count} + {1'b0, drop_cnt};
  assign credit_ok = in_flight < (CNT_W + 1)'(DEPTH);

  assign ar_addr        = fetch_pc;
  assign ar_valid       = ~rst & fetch_pc_valid & credit_ok & ~flush;
  assign fetch_pc_ready = ~rst & ar_ready & credit_ok & ~flush;
  assign ar_fire        = ar_valid & ar_ready;

  assign r_ready = ~rst;
  assign r_fire  = r_valid & r_ready;
  assign fill    = r_fire & ~flush & (drop_cnt == '0) & (pend_cnt != '0);

  assign inst_valid = ~rst & ~flush & (count != '0) & filled[head];
  assign inst_data  = data_mem[head];
  assign inst_pc    = pc_mem[head];
  assign inst_err   = err_mem[head];
  assign rel        = inst_valid & inst_ready;

  // A beat landing in the flush cycle belongs to the discarded stream.
  always_comb begin
    drop_flush = drop_cnt + pend_cnt;
    if (r_fire && (drop_flush != '0)) begin
      drop_flush = drop_flush - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (flush) begin
      head     <= tail;
      fill_ptr <= tail;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= drop_flush;
    end else begin
      if (ar_fire) begin
        tail         <= tail + PTR_W'(1);
        filled[tail] <= 1'b0;
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + PTR_W'(1);
        filled[fill_ptr] <= 1'b1;
      end
      if (rel) begin
        head <= head + PTR_W'(1);
      end
      count    <= count + CNT_W'(ar_fire) - CNT_W'(rel);
      pend_cnt <= pend_cnt + CNT_W'(ar_fire) - CNT_W'(fill);
      if (r_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count/filled.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      pc_mem[tail] <= fetch_pc;
    end
    if (fill) begin
      data_mem[fill_ptr] <= r_data;
      err_mem[fill_ptr]  <= |r_resp;
    end
  end

endmodule
`default_nettype wire
